// File: rtl/axi_lite_rr_arbiter.sv
// Purpose : N-master to 1-slave AXI-Lite arbiter with round-robin fairness. The grant is
//           held for one complete read (AR+R) or write (AW+W+B) transaction.
// Latency : 1 cycle from a request sampled in IDLE to its forwarding. After that every
//           handshake passes combinationally. One idle bubble follows each transaction.
// Backpressure: READY/VALID are wired straight between the granted master and the slave,
//           so either side may stall indefinitely. Non-granted masters see all READY/VALID
//           outputs and all data outputs held at 0.
// Ports   : CLK/RESETN (sync, active-low); M_* flattened master buses (master i at
//           [i*W +: W]); S_* single slave port; GRANT one-hot owner, 0 while IDLE.
module axi_lite_rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  // master side
  input  logic [NUM_M-1:0]       M_AWVALID,
  output logic [NUM_M-1:0]       M_AWREADY,
  input  logic [NUM_M*AW-1:0]    M_AWADDR,
  input  logic [NUM_M-1:0]       M_WVALID,
  output logic [NUM_M-1:0]       M_WREADY,
  input  logic [NUM_M*DW-1:0]    M_WDATA,
  input  logic [NUM_M*DW/8-1:0]  M_WSTRB,
  output logic [NUM_M-1:0]       M_BVALID,
  input  logic [NUM_M-1:0]       M_BREADY,
  output logic [NUM_M*2-1:0]     M_BRESP,
  input  logic [NUM_M-1:0]       M_ARVALID,
  output logic [NUM_M-1:0]       M_ARREADY,
  input  logic [NUM_M*AW-1:0]    M_ARADDR,
  output logic [NUM_M-1:0]       M_RVALID,
  input  logic [NUM_M-1:0]       M_RREADY,
  output logic [NUM_M*DW-1:0]    M_RDATA,
  output logic [NUM_M*2-1:0]     M_RRESP,
  // slave side
  output logic                   S_AWVALID,
  input  logic                   S_AWREADY,
  output logic [AW-1:0]          S_AWADDR,
  output logic                   S_WVALID,
  input  logic                   S_WREADY,
  output logic [DW-1:0]          S_WDATA,
  output logic [DW/8-1:0]        S_WSTRB,
  input  logic                   S_BVALID,
  output logic                   S_BREADY,
  input  logic [1:0]             S_BRESP,
  output logic                   S_ARVALID,
  input  logic                   S_ARREADY,
  output logic [AW-1:0]          S_ARADDR,
  input  logic                   S_RVALID,
  output logic                   S_RREADY,
  input  logic [DW-1:0]          S_RDATA,
  input  logic [1:0]             S_RRESP,
  // debug
  output logic [NUM_M-1:0]       GRANT
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   gnt_idx, gnt_idx_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]   gnt_inc;
  logic            aw_done, aw_done_nxt;
  logic            w_done, w_done_nxt;

  logic [NUM_M-1:0] req;
  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [IW:0]      cand;

  assign req     = M_ARVALID | M_AWVALID;
  assign gnt_inc = (gnt_idx == IW'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;
  assign GRANT   = (state == IDLE) ? '0 : ({{(NUM_M-1){1'b0}}, 1'b1} << gnt_idx);

  // First requester at or after rr_ptr; the candidate index wraps modulo NUM_M,
  // which need not be a power of two.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_M; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_M)) begin
        cand = cand - (IW+1)'(NUM_M);
      end
      if (!pick_vld && req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    rr_ptr_nxt  = rr_ptr;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;

    M_AWREADY = '0;
    M_WREADY  = '0;
    M_BVALID  = '0;
    M_BRESP   = '0;
    M_ARREADY = '0;
    M_RVALID  = '0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    S_AWVALID = 1'b0;
    S_AWADDR  = '0;
    S_WVALID  = 1'b0;
    S_WDATA   = '0;
    S_WSTRB   = '0;
    S_BREADY  = 1'b0;
    S_ARVALID = 1'b0;
    S_ARADDR  = '0;
    S_RREADY  = 1'b0;

    // Request-side payload follows the owner for the whole transaction.
    if (state != IDLE) begin
      S_ARADDR = M_ARADDR[gnt_idx*AW +: AW];
      S_AWADDR = M_AWADDR[gnt_idx*AW +: AW];
      S_WDATA  = M_WDATA[gnt_idx*DW +: DW];
      S_WSTRB  = M_WSTRB[gnt_idx*(DW/8) +: DW/8];
    end

    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_idx_nxt = pick_idx;
          // A master with both AR and AW pending is served read-first.
          state_nxt   = M_ARVALID[pick_idx] ? RD_ADDR : WR_ADDR;
        end
      end

      RD_ADDR: begin
        S_ARVALID          = M_ARVALID[gnt_idx];
        M_ARREADY[gnt_idx] = S_ARREADY;
        if (S_ARVALID && S_ARREADY) begin
          state_nxt = RD_DATA;
        end
      end

      RD_DATA: begin
        S_RREADY                  = M_RREADY[gnt_idx];
        M_RVALID[gnt_idx]         = S_RVALID;
        M_RDATA[gnt_idx*DW +: DW] = S_RDATA;
        M_RRESP[gnt_idx*2 +: 2]   = S_RRESP;
        if (S_RVALID && S_RREADY) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = gnt_inc;
        end
      end

      WR_ADDR: begin
        // AW and W complete independently; a finished channel stops
        // presenting to the slave so its beat is never repeated.
        S_AWVALID          = M_AWVALID[gnt_idx] & ~aw_done;
        M_AWREADY[gnt_idx] = S_AWREADY & ~aw_done;
        S_WVALID           = M_WVALID[gnt_idx] & ~w_done;
        M_WREADY[gnt_idx]  = S_WREADY & ~w_done;
        if (S_AWVALID && S_AWREADY) begin
          aw_done_nxt = 1'b1;
        end
        if (S_WVALID && S_WREADY) begin
          w_done_nxt = 1'b1;
        end
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt = WR_RESP;
        end
      end

      WR_RESP: begin
        S_BREADY                = M_BREADY[gnt_idx];
        M_BVALID[gnt_idx]       = S_BVALID;
        M_BRESP[gnt_idx*2 +: 2] = S_BRESP;
        if (S_BVALID && S_BREADY) begin
          state_nxt   = IDLE;
          rr_ptr_nxt  = gnt_inc;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
